uart_receiver: RTL and testbench
================================

# uart_receiver

Serial-to-parallel receive stage of the UART; it consumes the line driven by the transmitter. It uses 16x oversampling from an internal baud-tick divider and recovers 5–9 data bits, an optional parity bit, and 1 or 2 stop bits. Each received character is held in a single-entry holding register behind a full/read handshake, with sticky parity, framing and overrun flags. Frame format fields use the same bit layout as the transmitter's status word, so one control register drives both directions.

## Interface
- clock_frequency_register, 100_000_000: system clock frequency in Hz. Documentation only; it does not change behaviour.
- clk  in  1  system clock; all state changes on its rising edge.
- rst  in  1  asynchronous, active-high reset.
- RX  in  1  serial line, asynchronous to clk; idles high.
- Baud_Divisor  in  16  number of clk cycles per 1/16-bit tick; value 0 is treated as 1.
- Receiver_Control  in  8  [0] enable; [4:1] data-bit count; [5] parity enable; [7:6] stop bits (01 = one, 10 = two, other = one).
- RX_Read  in  1  one-cycle pulse that pops the holding register.
- RX_Data  out  9  received character, LSB = first bit on the line, zero-extended above the data-bit count.
- RX_Full  out  1  holding register contains an unread character.
- Receiver_Status  out  4  [0] busy (state ≠ IDLE); [1] parity_error; [2] framing_error; [3] overrun.

## Operation
- Input synchronizer: RX passes through a 2-flop synchronizer (flops reset to 1). All logic uses the synchronized value rx_s.
- Tick generator: a 16-bit counter raises `tick` for one clk every Baud_Divisor cycles. The counter reloads on reset, while enable = 0, and on start detection, so the start bit is phase-aligned.
- Oversample counter os_cnt (4 bits) advances on each tick. A bit is sampled when os_cnt == 7 (mid-bit).
- Data-bit field: values 5–9 are used as given; any other value is treated as 8.
- FSM states: IDLE, START, DATA, PARITY, STOP.
  - IDLE: a falling edge of rx_s (previous 1, now 0) goes to START with os_cnt = 0.
  - START: at the mid-bit sample, rx_s = 0 goes to DATA with bit index = 0. rx_s = 1 is a false start and returns to IDLE with no flags set.
  - DATA: samples are shifted into bit[index], then index increments. After the last bit, go to PARITY if parity is enabled, else to STOP.
  - PARITY: the expected bit is the XOR of the received data bits (even parity, matching the transmitter). A mismatch sets pe_pending.
  - STOP: each stop sample that reads 0 sets fe_pending.
    - With two stop bits, both are sampled, 16 ticks apart.
    - After the last stop sample, the frame completes and the FSM returns to IDLE on the same edge, so a start edge 8 ticks later is caught.
- Frame completion:
  - If RX_Full = 0, or RX_Read is asserted in the same cycle: load RX_Data, set RX_Full = 1, copy pe_pending / fe_pending into status[1] / status[2].
  - Otherwise: discard the new character, set overrun; RX_Data and the earlier error flags are unchanged.
- RX_Read while RX_Full = 1 with no simultaneous completion: clears RX_Full, parity_error, framing_error and overrun on the next edge. RX_Read while RX_Full = 0 has no effect.
- enable = 0: synchronously aborts any frame, returning to IDLE and clearing the counters and pending flags. RX_Data, RX_Full and the status flags are retained.
- Config changes mid-frame are undefined for that frame. Software changes config only while busy = 0.

## Timing
- Reset values:
  - RX_Data = 0, RX_Full = 0, Receiver_Status = 0.
  - FSM in IDLE; synchronizer flops = 1; all counters = 0.
- Reset asserted mid-frame aborts the frame immediately and asynchronously.
- Bit period = 16 × max(Baud_Divisor, 1) clk cycles.
- Latency from the RX pin edge to start detection: 2 clk (synchronizer) + 1 clk (edge register).
- RX_Full and the status flags rise 1 clk after the edge on which the final stop bit is sampled.
- RX_Read is accepted on any edge. A back-to-back read-and-load in the same cycle keeps RX_Full = 1 and does not set overrun.
- Minimum start-bit low time for acceptance: 8 ticks plus synchronizer delay. Glitches shorter than this are rejected as false starts.

## Test plan
- 8N1, divisor 1, frame 0xA5:
  - Expect RX_Data = 0x0A5, RX_Full = 1 and status = 0.
  - RX_Full rises 155 ± 2 clk after the start edge; busy drops when the frame completes.
- 7-bit, parity enabled, two stop bits, frames 0x55 (parity bit 0) and 0x55 (parity bit 1):
  - First frame: RX_Data = 0x055, parity_error = 0.
  - Second frame: parity_error = 1.
  - RX_Read clears RX_Full and parity_error.
- 5-bit and 9-bit frames 0x1F and 0x1A3:
  - Expect RX_Data = 0x01F and 0x1A3.
  - A stop bit driven to 0 sets framing_error = 1.
- Two back-to-back 8N1 frames without RX_Read:
  - overrun = 1 and RX_Data holds the first byte.
  - With RX_Read pulsed on the cycle of the second completion: RX_Data = second byte, overrun = 0.
- 4-tick low glitch on RX: busy pulses, then returns to IDLE with RX_Full = 0 and no flags.
- Reset and enable mid-frame:
  - Assert rst mid-data: all outputs = 0 immediately.
  - Drop enable mid-frame with RX_Full = 1: frame aborted, RX_Data and RX_Full retained.
  - The next valid frame after re-enable is received correctly.

Source files
------------

// File: rtl/uart_receiver_if.sv
// Host-side bundle of the UART receive stage: serial line, baud/format control,
// and the holding-register read handshake with its status word.
interface uart_receiver_if;
  logic        RX;
  logic [15:0] Baud_Divisor;
  logic [7:0]  Receiver_Control;
  logic        RX_Read;
  logic [8:0]  RX_Data;
  logic        RX_Full;
  logic [3:0]  Receiver_Status;

  modport master (
    output RX, Baud_Divisor, Receiver_Control, RX_Read,
    input  RX_Data, RX_Full, Receiver_Status
  );

  modport slave (
    input  RX, Baud_Divisor, Receiver_Control, RX_Read,
    output RX_Data, RX_Full, Receiver_Status
  );
endinterface

// File: rtl/uart_receiver.sv
// UART receive stage: 16x oversampled start/data/parity/stop recovery into a
// single-entry holding register with sticky parity, framing and overrun flags.
// Written for a 100 MHz system clock; the clock frequency does not affect behaviour.
module uart_receiver (
  input  logic           clk,
  input  logic           rst,
  uart_receiver_if.slave bus
);

  typedef enum logic [2:0] {IDLE, START, DATA, PARITY, STOP} state_t;

  state_t      state, state_next;
  logic        rx_meta, rx_s, rx_prev;
  logic [15:0] div_cnt, div_eff;
  logic        tick, sample;
  logic [3:0]  os_cnt, bit_idx, nbits;
  logic        stop_idx;
  logic [8:0]  shift;
  logic        pe_pending, fe_pending;
  logic        enable, par_en, two_stop;
  logic        start_det, complete, pe_hit, fe_hit;
  logic [8:0]  rx_data;
  logic        rx_full, pe_flag, fe_flag, ovr_flag;

  assign enable   = bus.Receiver_Control[0];
  assign par_en   = bus.Receiver_Control[5];
  assign two_stop = (bus.Receiver_Control[7:6] == 2'b10);
  assign nbits    = (bus.Receiver_Control[4:1] >= 4'd5 && bus.Receiver_Control[4:1] <= 4'd9)
                    ? bus.Receiver_Control[4:1] : 4'd8;
  assign div_eff  = (bus.Baud_Divisor == 16'd0) ? 16'd1 : bus.Baud_Divisor;
  assign tick     = (div_cnt >= div_eff - 16'd1);
  assign sample   = tick && (os_cnt == 4'd7);

  // Synchronizer and edge register reset high so reset release never looks like a start edge.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      rx_meta <= 1'b1;
      rx_s    <= 1'b1;
      rx_prev <= 1'b1;
    end else begin
      // NOTE: sequential state uses non-blocking (<=) so every flop samples pre-edge values.
      rx_meta <= bus.RX;
      rx_s    <= rx_meta;
      rx_prev <= rx_s;
    end
  end

  // Baud tick divider, restarted on start detection so ticks are phase-aligned to the start bit.
  always_ff @(posedge clk or posedge rst) begin
    if (rst)                            div_cnt <= '0;
    else if (!enable || start_det || tick) div_cnt <= '0;
    else                                div_cnt <= div_cnt + 16'd1;
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) state <= IDLE;
    else     state <= state_next;
  end

  always_comb begin
    // NOTE: every output gets a default first so no path leaves it unassigned (no latches).
    state_next = state;
    start_det  = 1'b0;
    complete   = 1'b0;
    pe_hit     = 1'b0;
    fe_hit     = 1'b0;
    unique case (state)
      IDLE: if (rx_prev && !rx_s) begin
        start_det  = 1'b1;
        state_next = START;
      end
      START: if (sample) state_next = rx_s ? IDLE : DATA;
      DATA: if (sample && bit_idx == nbits - 4'd1) state_next = par_en ? PARITY : STOP;
      PARITY: if (sample) begin
        pe_hit     = (rx_s != ^shift);
        state_next = STOP;
      end
      STOP: if (sample) begin
        fe_hit = !rx_s;
        if (!two_stop || stop_idx) begin
          complete   = 1'b1;
          state_next = IDLE;
        end
      end
      default: state_next = IDLE;
    endcase
    if (!enable) begin
      state_next = IDLE;
      start_det  = 1'b0;
      complete   = 1'b0;
      pe_hit     = 1'b0;
      fe_hit     = 1'b0;
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      os_cnt     <= '0;
      bit_idx    <= '0;
      stop_idx   <= 1'b0;
      shift      <= '0;
      pe_pending <= 1'b0;
      fe_pending <= 1'b0;
    end else if (!enable || start_det) begin
      os_cnt     <= '0;
      bit_idx    <= '0;
      stop_idx   <= 1'b0;
      pe_pending <= 1'b0;
      fe_pending <= 1'b0;
      if (start_det) shift <= '0;
    end else if (state != IDLE) begin
      if (tick) os_cnt <= os_cnt + 4'd1;
      if (sample && state == DATA) begin
        shift[bit_idx] <= rx_s;
        bit_idx        <= bit_idx + 4'd1;
      end
      if (sample && state == STOP) stop_idx <= 1'b1;
      if (pe_hit) pe_pending <= 1'b1;
      if (fe_hit) fe_pending <= 1'b1;
    end
  end

  // Holding register: a read in the completion cycle frees the slot for the new character.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      rx_data  <= '0;
      rx_full  <= 1'b0;
      pe_flag  <= 1'b0;
      fe_flag  <= 1'b0;
      ovr_flag <= 1'b0;
    end else if (complete) begin
      if (!rx_full || bus.RX_Read) begin
        rx_data  <= shift;
        rx_full  <= 1'b1;
        pe_flag  <= pe_pending;
        fe_flag  <= fe_pending || fe_hit;
        ovr_flag <= 1'b0;
      end else begin
        ovr_flag <= 1'b1;
      end
    end else if (bus.RX_Read && rx_full) begin
      rx_full  <= 1'b0;
      pe_flag  <= 1'b0;
      fe_flag  <= 1'b0;
      ovr_flag <= 1'b0;
    end
  end

  assign bus.RX_Data         = rx_data;
  assign bus.RX_Full         = rx_full;
  assign bus.Receiver_Status = {ovr_flag, fe_flag, pe_flag, state != IDLE};

endmodule

// File: tb/tb_uart_receiver.sv
// Self-checking bench for uart_receiver: frame-level reference model checked every
// cycle, directed corner cases with literal expectations, then randomized frames.
module tb_uart_receiver;

  typedef struct {
    int         at_edge;
    logic [8:0] data;
    bit         pe;
    bit         fe;
  } exp_frame_t;

  logic clk, rst;
  uart_receiver_if bus ();

  uart_receiver dut (
    .clk (clk),
    .rst (rst),
    .bus (bus.slave)
  );

  int checks   = 0;
  int failures = 0;
  int edge_cnt = 0;
  int lat;

  exp_frame_t pend[$];
  logic [8:0] m_data = '0;
  bit         m_full = 0, m_pe = 0, m_fe = 0, m_ovr = 0;

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s: actual=0x%0h expected=0x%0h", name, act, exp);
    end
  endtask

  function automatic logic [7:0] ctrl(input logic [3:0] nb_raw, input bit par,
                                      input logic [1:0] stop, input bit en);
    return {stop, par, nb_raw, en};
  endfunction

  // Frame-level model: a frame whose line falls just after edge N completes on edge
  // N + 3 + (8 + 16*(bits-1)) * divisor; then the holding-register rules apply.
  initial begin
    forever begin
      @(posedge clk);
      edge_cnt++;
      if (rst) begin
        m_data = '0; m_full = 0; m_pe = 0; m_fe = 0; m_ovr = 0;
        pend.delete();
      end else begin
        if (!bus.Receiver_Control[0]) pend.delete();
        if (pend.size() > 0 && pend[0].at_edge == edge_cnt) begin
          exp_frame_t f;
          f = pend.pop_front();
          if (!m_full || bus.RX_Read) begin
            m_data = f.data; m_full = 1; m_pe = f.pe; m_fe = f.fe; m_ovr = 0;
          end else begin
            m_ovr = 1;
          end
        end else if (bus.RX_Read && m_full) begin
          m_full = 0; m_pe = 0; m_fe = 0; m_ovr = 0;
        end
      end
    end
  end

  initial begin
    forever begin
      @(negedge clk);
      if (!rst)
        check("cycle_outputs", {bus.RX_Full, bus.Receiver_Status[3:1], bus.RX_Data},
              {m_full, m_ovr, m_fe, m_pe, m_data});
    end
  end

  initial begin
    #1_500_000;
    $display("FAIL watchdog: actual=timeout expected=finish");
    $fatal(1, "bench timed out");
  end

  // Call at a negedge. nb is the effective data-bit count (5..9).
  task automatic send_frame(input logic [8:0] data, input int nb, input bit par,
                            input bit two, input bit flip_par, input bit bad_stop);
    logic bits[$];
    logic [8:0] masked;
    exp_frame_t f;
    int d;
    d = (bus.Baud_Divisor == 16'd0) ? 1 : int'(bus.Baud_Divisor);
    masked = '0;
    bits.push_back(1'b0);
    for (int i = 0; i < nb; i++) begin
      bits.push_back(data[i]);
      masked[i] = data[i];
    end
    if (par) bits.push_back((^masked) ^ flip_par);
    bits.push_back(!bad_stop);
    if (two) bits.push_back(1'b1);
    f.at_edge = edge_cnt + 3 + (8 + 16 * (bits.size() - 1)) * d;
    f.data    = masked;
    f.pe      = par && flip_par;
    f.fe      = bad_stop;
    pend.push_back(f);
    foreach (bits[i]) begin
      bus.RX = bits[i];
      repeat (16 * d) @(negedge clk);
    end
    bus.RX = 1'b1;
  endtask

  task automatic read_pulse();
    bus.RX_Read = 1'b1;
    @(negedge clk);
    bus.RX_Read = 1'b0;
  endtask

  task automatic idle(input int n);
    repeat (n) @(negedge clk);
  endtask

  initial begin
    bus.RX = 1'b1;
    bus.Baud_Divisor = 16'd1;
    bus.Receiver_Control = 8'h00;
    bus.RX_Read = 1'b0;
    rst = 1'b1;
    idle(3);
    rst = 1'b0;
    idle(1);
    check("reset_data", bus.RX_Data, 9'h000);
    check("reset_full", bus.RX_Full, 1'b0);
    check("reset_status", bus.Receiver_Status, 4'h0);

    // 8N1, divisor 1, 0xA5 with completion latency
    bus.Receiver_Control = ctrl(4'd8, 0, 2'b01, 1);
    idle(4);
    fork
      send_frame(9'h0A5, 8, 0, 0, 0, 0);
      begin
        lat = 0;
        while (!bus.RX_Full && lat < 400) begin
          @(negedge clk);
          lat++;
        end
      end
    join
    check("8n1_latency_in_window", (lat >= 153 && lat <= 157), 1'b1);
    idle(4);
    check("8n1_data", bus.RX_Data, 9'h0A5);
    check("8n1_status", bus.Receiver_Status, 4'h0);
    read_pulse();
    check("8n1_read_clears_full", bus.RX_Full, 1'b0);

    // 7 data bits, even parity, two stop bits
    bus.Receiver_Control = ctrl(4'd7, 1, 2'b10, 1);
    idle(4);
    send_frame(9'h055, 7, 1, 1, 0, 0);
    idle(4);
    check("7e2_data", bus.RX_Data, 9'h055);
    check("7e2_good_parity_status", bus.Receiver_Status, 4'h0);
    read_pulse();
    send_frame(9'h055, 7, 1, 1, 1, 0);
    idle(4);
    check("7e2_bad_parity_status", bus.Receiver_Status, 4'h2);
    read_pulse();
    check("7e2_read_full", bus.RX_Full, 1'b0);
    check("7e2_read_status", bus.Receiver_Status, 4'h0);

    // 5 and 9 data bits, then a framing error
    bus.Receiver_Control = ctrl(4'd5, 0, 2'b01, 1);
    idle(4);
    send_frame(9'h01F, 5, 0, 0, 0, 0);
    idle(4);
    check("5bit_data", bus.RX_Data, 9'h01F);
    read_pulse();
    bus.Receiver_Control = ctrl(4'd9, 0, 2'b01, 1);
    idle(4);
    send_frame(9'h1A3, 9, 0, 0, 0, 0);
    idle(4);
    check("9bit_data", bus.RX_Data, 9'h1A3);
    read_pulse();
    bus.Receiver_Control = ctrl(4'd8, 0, 2'b01, 1);
    idle(4);
    send_frame(9'h05A, 8, 0, 0, 0, 1);
    idle(4);
    check("framing_status", bus.Receiver_Status, 4'h4);
    read_pulse();
    idle(4);

    // Back-to-back frames without a read: overrun keeps the first byte
    send_frame(9'h03C, 8, 0, 0, 0, 0);
    send_frame(9'h0C3, 8, 0, 0, 0, 0);
    idle(10);
    check("overrun_data", bus.RX_Data, 9'h03C);
    check("overrun_status", bus.Receiver_Status, 4'h8);
    read_pulse();
    check("overrun_read_full", bus.RX_Full, 1'b0);

    // Read pulsed exactly on the second completion edge (edge n1 + 160 + 155)
    begin
      int n1;
      n1 = edge_cnt;
      fork
        begin
          send_frame(9'h011, 8, 0, 0, 0, 0);
          send_frame(9'h022, 8, 0, 0, 0, 0);
        end
        begin
          while (edge_cnt < n1 + 314) @(negedge clk);
          read_pulse();
        end
      join
    end
    idle(4);
    check("read_and_load_data", bus.RX_Data, 9'h022);
    check("read_and_load_status", bus.Receiver_Status, 4'h0);
    check("read_and_load_full", bus.RX_Full, 1'b1);
    read_pulse();

    // 4-tick glitch: brief busy, then a rejected false start
    bus.RX = 1'b0;
    idle(4);
    bus.RX = 1'b1;
    check("glitch_busy", bus.Receiver_Status[0], 1'b1);
    idle(20);
    check("glitch_full", bus.RX_Full, 1'b0);
    check("glitch_status", bus.Receiver_Status, 4'h0);

    // Enable dropped mid-frame while holding an unread byte
    send_frame(9'h066, 8, 0, 0, 0, 0);
    idle(4);
    fork
      send_frame(9'h099, 8, 0, 0, 0, 0);
      begin
        idle(60);
        check("abort_busy_before", bus.Receiver_Status[0], 1'b1);
        bus.Receiver_Control[0] = 1'b0;
        idle(1);
        check("abort_busy_after", bus.Receiver_Status[0], 1'b0);
      end
    join
    idle(4);
    check("abort_data_kept", bus.RX_Data, 9'h066);
    check("abort_full_kept", bus.RX_Full, 1'b1);
    bus.Receiver_Control[0] = 1'b1;
    read_pulse();
    idle(2);
    send_frame(9'h03E, 8, 0, 0, 0, 0);
    idle(4);
    check("reenable_data", bus.RX_Data, 9'h03E);

    // Asynchronous reset mid-data with a full holding register
    fork
      send_frame(9'h077, 8, 0, 0, 0, 0);
      begin
        idle(70);
        #2 rst = 1'b1;
        #1;
        check("rst_data", bus.RX_Data, 9'h000);
        check("rst_full", bus.RX_Full, 1'b0);
        check("rst_status", bus.Receiver_Status, 4'h0);
      end
    join
    @(negedge clk);
    rst = 1'b0;
    idle(4);
    send_frame(9'h081, 8, 0, 0, 0, 0);
    idle(4);
    check("post_rst_data", bus.RX_Data, 9'h081);
    read_pulse();

    // Randomized formats, divisors, errors and read timing against the model
    for (int k = 0; k < 40; k++) begin
      int raw_nb, nb, stop_raw, div, d, bits_n, off, rd_mode, rd_at, gap;
      bit par, two, flip, bad;
      logic [8:0] data;
      div      = $urandom_range(0, 2);
      raw_nb   = $urandom_range(0, 15);
      nb       = (raw_nb >= 5 && raw_nb <= 9) ? raw_nb : 8;
      par      = 1'($urandom_range(0, 1));
      stop_raw = $urandom_range(0, 3);
      two      = (stop_raw == 2);
      flip     = ($urandom_range(0, 3) == 0);
      bad      = ($urandom_range(0, 5) == 0);
      data     = 9'($urandom_range(0, 511));
      bus.Baud_Divisor     = 16'(div);
      bus.Receiver_Control = {stop_raw[1:0], par, raw_nb[3:0], 1'b1};
      d       = (div == 0) ? 1 : div;
      bits_n  = 1 + nb + int'(par) + 1 + int'(two);
      off     = 3 + (8 + 16 * (bits_n - 1)) * d;
      rd_mode = $urandom_range(0, 3);
      rd_at   = (rd_mode == 0) ? off - 1 : $urandom_range(1, bits_n * 16 * d);
      gap     = bad ? $urandom_range(2, 12) : $urandom_range(0, 12);
      fork
        send_frame(data, nb, par, two, flip, bad);
        if (rd_mode != 3) begin
          idle(rd_at);
          read_pulse();
        end
      join
      idle(gap);
    end
    idle(20);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
